// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter for the UART TX FIFO push port; grant 1 cycle after req, bytes pass through combinationally.
// tx_full gates in_ready/tx_push directly; a stalled owner is released after TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   in_valid,
  input  logic [8*N-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [N-1:0]   grant,
  input  logic           tx_full,
  output logic           tx_push,
  output logic [7:0]     tx_push_data,
  output logic           busy,
  output logic           pkt_done,
  output logic           abort
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          state_q;
  logic [N-1:0]    grant_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            pkt_done_q;
  logic            abort_q;

  logic            xfer;
  logic            own_vld;
  logic            own_last;
  logic [7:0]      own_dat;
  logic            push;

  logic            pick_vld;
  logic [IW-1:0]   owner_d;
  logic [N-1:0]    grant_d;

  assign xfer     = (state_q == XFER);
  assign own_vld  = in_valid[owner_q];
  assign own_last = in_last[owner_q];
  assign own_dat  = in_data[{owner_q, 3'b000} +: 8];
  assign push     = xfer & own_vld & ~tx_full;

  assign in_ready     = (xfer && !tx_full) ? grant_q : '0;
  assign tx_push      = push;
  assign tx_push_data = push ? own_dat : 8'h00;
  assign grant        = grant_q;
  assign busy         = xfer;
  assign pkt_done     = pkt_done_q;
  assign abort        = abort_q;

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    logic [IW-1:0] cand;
    cand     = '0;
    pick_vld = 1'b0;
    owner_d  = '0;
    grant_d  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        owner_d  = cand;
      end
    end
    if (pick_vld) grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= IW'(N - 1);
      cnt_q      <= '0;
      pkt_done_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= XFER;
            grant_q <= grant_d;
            owner_q <= owner_d;
            cnt_q   <= '0;
          end
        end
        XFER: begin
          if (push && own_last) begin
            pkt_done_q <= 1'b1;
            ptr_q      <= owner_q;
            grant_q    <= '0;
            state_q    <= IDLE;
          end else if (own_vld) begin
            // Offered data (even if held off by tx_full) proves the owner is alive.
            cnt_q <= '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            abort_q <= 1'b1;
            ptr_q   <= owner_q;
            grant_q <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a queue-based packet model.
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   in_valid;
  logic [8*N-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   grant;
  logic           tx_full;
  logic           tx_push;
  logic [7:0]     tx_push_data;
  logic           busy;
  logic           pkt_done;
  logic           abort;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .grant(grant), .tx_full(tx_full),
    .tx_push(tx_push), .tx_push_data(tx_push_data), .busy(busy),
    .pkt_done(pkt_done), .abort(abort)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: owner index (-1 idle), last-owner pointer, consecutive idle count.
  int m_owner, m_ptr, m_stall;
  bit e_done, e_abort;

  logic [8:0]   src [N][$];
  logic [N-1:0] req_en;
  logic [N-1:0] hold;
  bit           rand_mode;
  logic [7:0]   log_q [$];
  int           push_step [$];
  int           step_no;
  int           done_step, abort_step, abort_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int n, input logic [63:0] ev);
    check({tag, "_len"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      check(tag, 32'(log_q[i]), 32'(ev[8*i +: 8]));
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input bit last);
    src[r].push_back({last, d});
  endtask

  function automatic bit pending();
    if (m_owner >= 0) return 1'b1;
    for (int i = 0; i < N; i++)
      if (src[i].size() > 0 && req_en[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_model();
    m_owner = -1;
    m_ptr   = N - 1;
    m_stall = 0;
    for (int i = 0; i < N; i++) src[i].delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; in_valid = '0; in_last = '0; in_data = '0; tx_full = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_push", tx_push, 0);
    check("rst_push_data", tx_push_data, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", pkt_done, 0);
    check("rst_abort", abort, 0);
    reset_model();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock: drive sources, check combinational outputs, advance model, check registered outputs.
  task automatic step();
    logic [N-1:0] exp_gnt, exp_rdy;
    logic         exp_push;
    logic [7:0]   exp_dat;
    logic [8:0]   b;
    bit           has, stop;
    int           o, idx;
    for (int i = 0; i < N; i++) begin
      has = (src[i].size() > 0);
      req[i]      = has && req_en[i];
      in_valid[i] = has && !hold[i] && (!rand_mode || $urandom_range(99) < 75);
      in_data[i*8 +: 8] = has ? src[i][0][7:0] : 8'($urandom);
      in_last[i]  = has ? src[i][0][8] : 1'($urandom);
    end
    if (rand_mode) tx_full = ($urandom_range(99) < 20);
    #2;
    o = m_owner;
    exp_gnt = '0;
    exp_push = 1'b0;
    exp_dat = 8'h00;
    if (o >= 0) begin
      exp_gnt[o] = 1'b1;
      exp_push = in_valid[o] && !tx_full;
      if (exp_push) exp_dat = in_data[o*8 +: 8];
    end
    exp_rdy = (o >= 0 && !tx_full) ? exp_gnt : '0;
    check("grant", grant, exp_gnt);
    check("busy", busy, o >= 0);
    check("in_ready", in_ready, exp_rdy);
    check("tx_push", tx_push, exp_push);
    check("tx_push_data", tx_push_data, exp_dat);
    check("grant_onehot0", $onehot0(grant), 1);
    if (tx_push === 1'b1) begin
      log_q.push_back(tx_push_data);
      push_step.push_back(step_no);
    end
    e_done = 1'b0;
    e_abort = 1'b0;
    if (o < 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && req[idx]) begin
          m_owner = idx;
          m_stall = 0;
        end
      end
    end else if (exp_push) begin
      void'(src[o].pop_front());
      m_stall = 0;
      if (in_last[o]) begin
        e_done = 1'b1;
        m_ptr = o;
        m_owner = -1;
      end
    end else if (in_valid[o]) begin
      m_stall = 0;
    end else begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        e_abort = 1'b1;
        m_ptr = o;
        m_owner = -1;
        stop = 1'b0;
        while (!stop && src[o].size() > 0) begin
          b = src[o].pop_front();
          stop = b[8];
        end
      end
    end
    @(posedge clk); #1;
    step_no++;
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    check("pkt_done", pkt_done, e_done);
    check("abort", abort, e_abort);
    check("grant_post", grant, exp_gnt);
    check("busy_post", busy, m_owner >= 0);
    if (pkt_done === 1'b1) done_step = step_no;
    if (abort === 1'b1) begin
      abort_step = step_no;
      abort_cnt++;
    end
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 32'(pending()), 0);
  endtask

  initial begin
    int s0, r, len;
    rst = 1'b1; req = '0; in_valid = '0; in_data = '0; in_last = '0; tx_full = 1'b0;
    req_en = '1; hold = '0; rand_mode = 1'b0; step_no = 0;
    done_step = -1; abort_step = -1; abort_cnt = 0;
    #2;
    do_reset();

    // Single requester, 3-byte packet
    add_byte(0, 8'h41, 0); add_byte(0, 8'h42, 0); add_byte(0, 8'h43, 1);
    log_q.delete(); s0 = step_no;
    run_until_idle("t1", 50);
    check_log("t1_bytes", 3, 64'h434241);
    check("t1_done_latency", 32'(done_step - s0), 4);

    // Round robin from reset
    do_reset();
    add_byte(0, 8'h00, 1); add_byte(1, 8'h01, 1); add_byte(2, 8'h02, 1);
    add_byte(3, 8'h03, 1); add_byte(0, 8'h00, 1);
    log_q.delete(); push_step.delete();
    run_until_idle("t2", 50);
    check_log("t2_order", 5, 64'h0003020100);
    for (int i = 1; i < push_step.size(); i++)
      check("t2_gap", 32'(push_step[i] - push_step[i-1]), 2);

    // Back-pressure mid-packet
    log_q.delete(); abort_cnt = 0;
    add_byte(1, 8'hA0, 0); add_byte(1, 8'hA1, 0); add_byte(1, 8'hA2, 0); add_byte(1, 8'hA3, 1);
    step(); step(); step();
    tx_full = 1'b1;
    repeat (5) step();
    tx_full = 1'b0;
    run_until_idle("t3", 50);
    check_log("t3_bytes", 4, 64'hA3A2A1A0);
    check("t3_no_abort", 32'(abort_cnt), 0);

    // Packet lock: owner drops req, others request mid-packet
    log_q.delete();
    add_byte(1, 8'h11, 0); add_byte(1, 8'h12, 0); add_byte(1, 8'h13, 1);
    step(); step();
    req_en[1] = 1'b0;
    add_byte(0, 8'h00, 1); add_byte(2, 8'h20, 1);
    run_until_idle("t4", 50);
    req_en[1] = 1'b1;
    check_log("t4_order", 5, 64'h0020131211);

    // Stall timeout
    log_q.delete(); abort_step = -1;
    add_byte(3, 8'h30, 0); add_byte(3, 8'h31, 0); add_byte(3, 8'h32, 1);
    step(); step();
    s0 = step_no;
    hold[3] = 1'b1;
    add_byte(0, 8'h05, 1);
    run_until_idle("t5", 100);
    hold[3] = 1'b0;
    check("t5_abort_latency", 32'(abort_step - s0), 16);
    check_log("t5_bytes", 2, 64'h0530);

    // Asynchronous reset mid-packet
    add_byte(2, 8'h50, 0); add_byte(2, 8'h51, 1);
    step(); step();
    in_valid = 4'b0100; in_data[23:16] = 8'h51; in_last = 4'b0100; tx_full = 1'b0;
    #1;
    check("t6_pre_push", tx_push, 1);
    rst = 1'b0;
    #1;
    check("t6_grant", grant, 0);
    check("t6_busy", busy, 0);
    check("t6_push", tx_push, 0);
    check("t6_ready", in_ready, 0);
    reset_model();
    @(posedge clk); #1;
    rst = 1'b1;
    log_q.delete();
    add_byte(3, 8'h63, 1); add_byte(0, 8'h60, 1);
    run_until_idle("t6", 50);
    check_log("t6_order", 2, 64'h6360);

    // Random traffic with random back-pressure
    rand_mode = 1'b1;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(99) < 15) begin
        r = $urandom_range(N - 1);
        len = 1 + $urandom_range(3);
        if (src[r].size() < 12)
          for (int j = 0; j < len; j++) add_byte(r, 8'($urandom), j == len - 1);
      end
      step();
    end
    rand_mode = 1'b0;
    tx_full = 1'b0;
    run_until_idle("rand", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single UART TX FIFO push port of uart_controller between N byte-stream requesters (e.g. clock display, stopwatch, sensor reporter). A granted requester is locked until its last byte is pushed, so packets never interleave on the serial line. It pushes directly into tx_push/tx_push_data and honours tx_full back-pressure. A stall timeout releases a requester that stops supplying data mid-packet.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 1_000_000, consecutive granted cycles with in_valid low before forced release (10 ms at 100 MHz)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
req  input  N  per-requester packet request; level, held until granted
in_valid  input  N  per-requester byte valid
in_data  input  8*N  per-requester byte; requester i on bits [8i+7:8i]
in_last  input  N  marks final byte of packet; qualified by in_valid
in_ready  output  N  byte accepted this cycle (valid&ready = transfer)
grant  output  N  one-hot current owner; all-zero when idle
tx_full  input  1  TX FIFO full flag from uart_controller
tx_push  output  1  FIFO push strobe
tx_push_data  output  8  FIFO push byte
busy  output  1  high while a packet is owned
pkt_done  output  1  1-cycle pulse on acceptance of the last byte
abort  output  1  1-cycle pulse on timeout release

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, rr pointer=N-1 (requester 0 wins first), timeout counter=0, pkt_done=0, abort=0. in_ready, tx_push and busy evaluate to 0 while in reset. tx_push_data evaluates to 0 while tx_push=0.
- States: IDLE, XFER.
- IDLE: the first set req bit searched from (ptr+1) mod N upward with wrap is registered into grant; state goes to XFER on the same edge. If no req bit is set, remain in IDLE.
- Arbitration latency: req sampled high at edge k gives grant high after edge k. No bytes transfer in IDLE.
- XFER, owner g:
  - in_ready[g] = ~tx_full. All other in_ready bits = 0.
  - tx_push = in_valid[g] & ~tx_full (combinational, zero latency, so a push never occurs while full).
  - tx_push_data = in_data[g].
- Last byte: a transfer with in_last[g]=1 pulses pkt_done in the following cycle (registered). On the same edge: ptr<=g, grant<=0, state<=IDLE. The minimum gap between packets is one IDLE cycle.
- Packet lock: req changes during XFER are ignored, including deassertion by the owner. Non-owners' in_valid and in_last are ignored.
- Timeout counter:
  - Increments each XFER cycle where in_valid[g]=0.
  - Clears on any cycle with in_valid[g]=1, whether accepted or stalled by tx_full. A tx_full stall therefore never times out.
  - Clears on entry to XFER.
  - When the count reaches TIMEOUT-1 with in_valid[g] still 0: abort pulses the next cycle, ptr<=g, grant<=0, state<=IDLE. No byte is pushed for the aborted remainder.
- Counter width: $clog2(TIMEOUT+1). No wrap, because it is cleared before reaching TIMEOUT.
- busy = (state==XFER).
- Reset asserted mid-packet: everything clears immediately. A partial packet already pushed stays in the FIFO; the arbiter does not clean it up.
- Single-byte packet (valid&last on the first XFER cycle): one push, then pkt_done.

Test Plan:
- Single requester: req[0]=1, 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> grant=0001 one cycle after req; tx_push high 3 consecutive cycles with data 41,42,43; pkt_done one cycle after 0x43; busy falls; grant=0000.
- Round robin: req=1111, every requester sends a 1-byte packet with data=index -> push order 00,01,02,03,00. Exactly one IDLE cycle between packets. grant is never multi-hot.
- Back-pressure: owner streams 4 bytes, tx_full=1 for 5 cycles after byte 2 -> tx_push=0 and in_ready=0 during the stall, no abort, bytes 3-4 pushed after tx_full falls, no byte lost or duplicated.
- Lock: owner 1 mid-packet, req[0] asserted and owner deasserts req[1] -> grant stays 0010 until last; next grant goes to requester 2 if requesting, else wraps to 0.
- Timeout (TIMEOUT=16): owner sends 1 byte then drops in_valid -> abort pulses exactly 16 cycles later, grant=0, next pending requester granted after one IDLE cycle; no further pushes from the aborted owner.
- Reset mid-packet: rst low during XFER -> grant, busy and tx_push go 0 immediately without a clock. After release, requester 0 wins first regardless of the previous pointer.
